// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared seven-segment definitions: glyph encodings (active-low {g..a}) and
// one-cold anode patterns, common to the display driver and the scan decoder.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  localparam logic [NUM_DIGITS-1:0][3:0] ANODE_ONE_COLD = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Index = nibble value; listed F down to 0 so element i holds glyph i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } glyph_t;

  function automatic logic is_one_cold(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic logic [1:0] cold_pos(input logic [3:0] an);
    logic [1:0] pos;
    pos = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an[i]) pos = 2'(i);
    return pos;
  endfunction

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Multiplexed display bus in, decoded word and status out.
interface seven_segment_scan_decoder_if;
  logic [6:0]  seg_in;
  logic [3:0]  anode_in;
  logic [15:0] value_out;
  logic        frame_valid;
  logic [3:0]  digit_mask;
  logic        decode_error;
  logic        timeout;

  modport master (
    output seg_in, anode_in,
    input  value_out, frame_valid, digit_mask, decode_error, timeout
  );

  modport slave (
    input  seg_in, anode_in,
    output value_out, frame_valid, digit_mask, decode_error, timeout
  );
endinterface

// File: rtl/seven_segment_scan_decoder_glyph.sv
// Reverse glyph lookup: active-low segment pattern to {hit, nibble}.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output glyph_t     glyph
);

  always_comb begin
    glyph = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        glyph.hit    = 1'b1;
        glyph.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Receive end of a multiplexed 4-digit seven-segment bus: synchronise, wait
// for a stable dwell, decode one digit per dwell and publish complete words.
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SCAN_TIMEOUT  = 400_000
) (
  input logic                          clk,
  input logic                          rst_n,
  seven_segment_scan_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(SCAN_TIMEOUT + 1);

  localparam logic [0:0] ST_SETTLING = 1'b0;
  localparam logic [0:0] ST_HOLD     = 1'b1;

  logic [10:0]           sync1_q, sync2_q, prev_q;
  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [3:0][3:0]       shadow_q, shadow_d;
  logic [3:0]            mask_q, mask_d;
  logic [15:0]           value_q, value_d;
  logic                  fv_q, fv_d;
  logic                  derr_q, derr_d;
  logic                  timeout_q, timeout_d;

  logic [3:0]            anode_s;
  logic [6:0]            seg_s;
  logic                  changed, eval, enabled, capture;
  logic [1:0]            pos;
  logic [3:0]            mask_next;
  glyph_t                glyph;

  assign anode_s = sync2_q[10:7];
  assign seg_s   = sync2_q[6:0];
  assign changed = (sync2_q != prev_q);
  assign eval    = (state_q == ST_SETTLING) && !changed &&
                   (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign enabled = is_one_cold(anode_s);
  assign pos     = cold_pos(anode_s);
  assign capture = eval && enabled && glyph.hit;

  seven_seg_glyph_decode u_glyph (
    .pattern (seg_s),
    .glyph   (glyph)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    shadow_d  = shadow_q;
    mask_d    = mask_q;
    value_d   = value_q;
    fv_d      = 1'b0;
    derr_d    = 1'b0;
    timeout_d = timeout_q;
    mask_next = mask_q;

    // One evaluation per dwell: HOLD blocks recapture until the bus moves.
    if (changed) begin
      state_d = ST_SETTLING;
      cnt_d   = '0;
    end else if (eval) begin
      state_d = ST_HOLD;
    end else if (state_q == ST_SETTLING) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (eval && enabled && !glyph.hit)
      derr_d = 1'b1;

    if (capture) begin
      shadow_d[pos] = glyph.nibble;
      mask_next     = mask_q | (4'b0001 << pos);
      if (mask_next == 4'b1111) begin
        value_d = shadow_d;
        fv_d    = 1'b1;
        mask_d  = 4'b0000;
      end else begin
        mask_d  = mask_next;
      end
    end

    // Capture outranks a timeout landing on the same edge.
    if (capture) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else begin
      if (to_cnt_q != TO_W'(SCAN_TIMEOUT))
        to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_d == TO_W'(SCAN_TIMEOUT)) begin
        timeout_d = 1'b1;
        mask_d    = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      state_q   <= ST_SETTLING;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      fv_q      <= 1'b0;
      derr_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= {bus.anode_in, bus.seg_in};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      fv_q      <= fv_d;
      derr_q    <= derr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.value_out    = value_q;
  assign bus.frame_valid  = fv_q;
  assign bus.digit_mask   = mask_q;
  assign bus.decode_error = derr_q;
  assign bus.timeout      = timeout_q;

endmodule
